// File: rtl/camera_reg_mc_pkg.sv
// Shared definitions for the multi-channel camera cfg register file:
// word addresses, STATUS bit positions, commit FSM states and the camera
// configuration set (used for both the shadow and the active copy).
package camera_reg_mc_pkg;

  localparam int unsigned DEST_W = 8;
  typedef logic [DEST_W-1:0] ch_dest_t;

  // Register offsets inside one RX channel block (word 4c+r)
  localparam logic [1:0] CH_SADDR = 2'd0;
  localparam logic [1:0] CH_SIZE  = 2'd1;
  localparam logic [1:0] CH_CFG   = 2'd2;
  localparam logic [1:0] CH_DEST  = 2'd3;

  // Camera block word addresses
  localparam logic [4:0] ADDR_GLOB      = 5'd16;
  localparam logic [4:0] ADDR_LL        = 5'd17;
  localparam logic [4:0] ADDR_UR        = 5'd18;
  localparam logic [4:0] ADDR_SIZE      = 5'd19;
  localparam logic [4:0] ADDR_FILTER    = 5'd20;
  localparam logic [4:0] ADDR_VSYNC_POL = 5'd21;
  localparam logic [4:0] ADDR_COMMIT    = 5'd22;
  localparam logic [4:0] ADDR_STATUS    = 5'd23;
  localparam logic [4:0] ADDR_FRAME_CNT = 5'd24;
  localparam logic [4:0] ADDR_IRQ_MASK  = 5'd25;

  // STATUS bit indices
  localparam int unsigned STAT_FRAME_DONE     = 0;
  localparam int unsigned STAT_OVERFLOW       = 1;
  localparam int unsigned STAT_COMMIT_APPLIED = 2;
  localparam int unsigned N_STAT              = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [31:0] glob;
    logic [31:0] ll;
    logic [31:0] ur;
    logic [31:0] size;
    logic [31:0] filter;
    logic        vsync_pol;
  } cam_cfg_t;

endpackage

// File: rtl/camera_rx_ch_regs.sv
// One uDMA RX channel: start address, size, cfg fields, destination,
// the one-cycle en/clr pulses and the channel's read-back mux.
module camera_rx_ch_regs
  import camera_reg_mc_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      wr_i,
  input  logic [1:0]                reg_i,
  input  logic [31:0]               wdata_i,
  output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
  output logic [TRANS_SIZE-1:0]     size_o,
  output logic [1:0]                datasize_o,
  output logic                      continuous_o,
  output logic                      en_o,
  output logic                      clr_o,
  output logic [DEST_W-1:0]         dest_o,
  input  logic                      en_i,
  input  logic                      pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     bytes_left_i,
  output logic [31:0]               rdata_o
);

  // Channel registers; en/clr self-clear so a CFG write yields single pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      startaddr_o  <= '0;
      size_o       <= '0;
      datasize_o   <= '0;
      continuous_o <= 1'b0;
      en_o         <= 1'b0;
      clr_o        <= 1'b0;
      dest_o       <= '0;
    end else begin
      en_o  <= 1'b0;
      clr_o <= 1'b0;
      if (wr_i) begin
        case (reg_i)
          CH_SADDR: startaddr_o <= wdata_i[L2_AWIDTH_NOAL-1:0];
          CH_SIZE:  size_o      <= wdata_i[TRANS_SIZE-1:0];
          CH_CFG: begin
            clr_o        <= wdata_i[6];
            en_o         <= wdata_i[4];
            datasize_o   <= wdata_i[2:1];
            continuous_o <= wdata_i[0];
          end
          default:  dest_o      <= wdata_i[DEST_W-1:0];
        endcase
      end
    end
  end

  // Read-back: address/size report live uDMA progress, not the programmed values
  always_comb begin
    rdata_o = '0;
    case (reg_i)
      CH_SADDR: rdata_o = 32'(curr_addr_i);
      CH_SIZE:  rdata_o = 32'(bytes_left_i);
      CH_CFG:   rdata_o = {26'b0, pending_i, en_i, 1'b0, datasize_o, continuous_o};
      default:  rdata_o = 32'(dest_o);
    endcase
  end

endmodule

// File: rtl/camera_reg_if_mc.sv
// Multi-channel camera cfg register file between the uDMA cfg bus and the
// camera core. Camera cfg is double-buffered (shadow -> active on COMMIT,
// applied at a frame boundary or immediately when the camera is idle).
// Optional feature macro: CAMERA_REG_IF_MC_IRQ_EN (IRQ_MASK register + irq_o).
//
// state | meaning
// IDLE  | no commit outstanding
// ARMED | commit requested while camera running; waits for frame end or stop
module camera_reg_if_mc
  import camera_reg_mc_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned N_CH           = 2,
  parameter int unsigned FCNT_W         = 16
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [31:0]                    cfg_data_i,
  input  logic [4:0]                     cfg_addr_i,
  input  logic                           cfg_valid_i,
  input  logic                           cfg_rwn_i,
  output logic [31:0]                    cfg_data_o,
  output logic                           cfg_ready_o,
  output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [N_CH*2-1:0]              cfg_rx_datasize_o,
  output logic [N_CH-1:0]                cfg_rx_continuous_o,
  output logic [N_CH-1:0]                cfg_rx_en_o,
  output logic [N_CH-1:0]                cfg_rx_clr_o,
  output logic [N_CH*DEST_W-1:0]         cfg_rx_dest_o,
  input  logic [N_CH-1:0]                cfg_rx_en_i,
  input  logic [N_CH-1:0]                cfg_rx_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  input  logic                           cam_ip_en_i,
  input  logic                           cam_frame_done_i,
  input  logic                           cam_overflow_i,
  output logic [31:0]                    cfg_cam_glob_o,
  output logic [31:0]                    cfg_cam_ll_o,
  output logic [31:0]                    cfg_cam_ur_o,
  output logic [31:0]                    cfg_cam_size_o,
  output logic [31:0]                    cfg_cam_filter_o,
  output logic                           cfg_cam_vsync_polarity_o,
  output logic                           irq_o
);

  logic                wr_en;
  logic                commit_wr;
  logic                do_copy;
  logic [N_STAT-1:0]   stat_set;
  logic [N_STAT-1:0]   stat_w1c;
  logic [N_STAT-1:0]   status_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [31:0]         ch_rdata [N_CH];
  cam_cfg_t            shadow_q;
  cam_cfg_t            active_q;
  commit_state_e       state_q, state_d;

  assign cfg_ready_o = 1'b1;
  assign wr_en       = cfg_valid_i & ~cfg_rwn_i;
  assign commit_wr   = wr_en & (cfg_addr_i == ADDR_COMMIT) & cfg_data_i[0];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    camera_rx_ch_regs #(
      .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
      .TRANS_SIZE     (TRANS_SIZE)
    ) u_ch (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .wr_i         (wr_en & ~cfg_addr_i[4] & (cfg_addr_i[3:2] == 2'(c))),
      .reg_i        (cfg_addr_i[1:0]),
      .wdata_i      (cfg_data_i),
      .startaddr_o  (cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
      .size_o       (cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
      .datasize_o   (cfg_rx_datasize_o[c*2 +: 2]),
      .continuous_o (cfg_rx_continuous_o[c]),
      .en_o         (cfg_rx_en_o[c]),
      .clr_o        (cfg_rx_clr_o[c]),
      .dest_o       (cfg_rx_dest_o[c*DEST_W +: DEST_W]),
      .en_i         (cfg_rx_en_i[c]),
      .pending_i    (cfg_rx_pending_i[c]),
      .curr_addr_i  (cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
      .bytes_left_i (cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
      .rdata_o      (ch_rdata[c])
    );
  end

  // Commit FSM state register; reset drops any pending commit
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Commit FSM next state; a stopped camera while ARMED counts as a frame boundary
  always_comb begin
    state_d = state_q;
    do_copy = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_wr) begin
          if (cam_ip_en_i) state_d = ARMED;
          else             do_copy = 1'b1;
        end
      end
      default: begin
        if (cam_frame_done_i || !cam_ip_en_i) begin
          do_copy = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Shadow set written by SW; active takes the pre-edge shadow so a same-cycle write stays shadow-only
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (do_copy) active_q <= shadow_q;
      if (wr_en) begin
        case (cfg_addr_i)
          ADDR_GLOB:      shadow_q.glob      <= cfg_data_i;
          ADDR_LL:        shadow_q.ll        <= cfg_data_i;
          ADDR_UR:        shadow_q.ur        <= cfg_data_i;
          ADDR_SIZE:      shadow_q.size      <= cfg_data_i;
          ADDR_FILTER:    shadow_q.filter    <= cfg_data_i;
          ADDR_VSYNC_POL: shadow_q.vsync_pol <= cfg_data_i[0];
          default: ;
        endcase
      end
    end
  end

  assign cfg_cam_glob_o           = active_q.glob;
  assign cfg_cam_ll_o             = active_q.ll;
  assign cfg_cam_ur_o             = active_q.ur;
  assign cfg_cam_size_o           = active_q.size;
  assign cfg_cam_filter_o         = active_q.filter;
  assign cfg_cam_vsync_polarity_o = active_q.vsync_pol;

  always_comb begin
    stat_set                      = '0;
    stat_set[STAT_FRAME_DONE]     = cam_frame_done_i;
    stat_set[STAT_OVERFLOW]       = cam_overflow_i;
    stat_set[STAT_COMMIT_APPLIED] = do_copy;
    stat_w1c = (wr_en && cfg_addr_i == ADDR_STATUS) ? cfg_data_i[N_STAT-1:0] : '0;
  end

  // Sticky status; a set event wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) status_q <= '0;
    else         status_q <= (status_q & ~stat_w1c) | stat_set;
  end

  // Frame counter; a write clears it and beats a same-cycle frame_done
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                    fcnt_q <= '0;
    else if (wr_en && cfg_addr_i == ADDR_FRAME_CNT) fcnt_q <= '0;
    else if (cam_frame_done_i)                      fcnt_q <= fcnt_q + 1'b1;
  end

`ifdef CAMERA_REG_IF_MC_IRQ_EN
  logic [N_STAT-1:0] irq_mask_q;

  // Interrupt mask register and registered interrupt line
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_mask_q <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (wr_en && cfg_addr_i == ADDR_IRQ_MASK) irq_mask_q <= cfg_data_i[N_STAT-1:0];
      irq_o <= |(status_q & irq_mask_q);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  // Combinational read mux; unmapped channels and addresses read 0
  always_comb begin
    cfg_data_o = '0;
    if (!cfg_addr_i[4]) begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_addr_i[3:2] == 2'(c)) cfg_data_o = ch_rdata[c];
      end
    end else begin
      case (cfg_addr_i)
        ADDR_GLOB:      cfg_data_o = {cam_ip_en_i, shadow_q.glob[30:0]};
        ADDR_LL:        cfg_data_o = shadow_q.ll;
        ADDR_UR:        cfg_data_o = shadow_q.ur;
        ADDR_SIZE:      cfg_data_o = shadow_q.size;
        ADDR_FILTER:    cfg_data_o = shadow_q.filter;
        ADDR_VSYNC_POL: cfg_data_o = {31'b0, shadow_q.vsync_pol};
        ADDR_COMMIT:    cfg_data_o = {31'b0, state_q == ARMED};
        ADDR_STATUS:    cfg_data_o = 32'(status_q);
        ADDR_FRAME_CNT: cfg_data_o = 32'(fcnt_q);
`ifdef CAMERA_REG_IF_MC_IRQ_EN
        ADDR_IRQ_MASK:  cfg_data_o = 32'(irq_mask_q);
`endif
        default:        cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_reg_if_mc.sv
// Directed bench for camera_reg_if_mc (N_CH=2, FCNT_W=4).
module tb_camera_reg_if_mc;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] cfg_data_i;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic [23:0] cfg_rx_startaddr_o;
  logic [31:0] cfg_rx_size_o;
  logic [3:0]  cfg_rx_datasize_o;
  logic [1:0]  cfg_rx_continuous_o;
  logic [1:0]  cfg_rx_en_o;
  logic [1:0]  cfg_rx_clr_o;
  logic [15:0] cfg_rx_dest_o;
  logic [1:0]  cfg_rx_en_i;
  logic [1:0]  cfg_rx_pending_i;
  logic [23:0] cfg_rx_curr_addr_i;
  logic [31:0] cfg_rx_bytes_left_i;
  logic        cam_ip_en_i;
  logic        cam_frame_done_i;
  logic        cam_overflow_i;
  logic [31:0] cfg_cam_glob_o, cfg_cam_ll_o, cfg_cam_ur_o, cfg_cam_size_o, cfg_cam_filter_o;
  logic        cfg_cam_vsync_polarity_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;

  always #5 clk_i = ~clk_i;

  camera_reg_if_mc #(
    .L2_AWIDTH_NOAL (12),
    .TRANS_SIZE     (16),
    .N_CH           (2),
    .FCNT_W         (4)
  ) dut (
    .clk_i                    (clk_i),
    .rstn_i                   (rstn_i),
    .cfg_data_i               (cfg_data_i),
    .cfg_addr_i               (cfg_addr_i),
    .cfg_valid_i              (cfg_valid_i),
    .cfg_rwn_i                (cfg_rwn_i),
    .cfg_data_o               (cfg_data_o),
    .cfg_ready_o              (cfg_ready_o),
    .cfg_rx_startaddr_o       (cfg_rx_startaddr_o),
    .cfg_rx_size_o            (cfg_rx_size_o),
    .cfg_rx_datasize_o        (cfg_rx_datasize_o),
    .cfg_rx_continuous_o      (cfg_rx_continuous_o),
    .cfg_rx_en_o              (cfg_rx_en_o),
    .cfg_rx_clr_o             (cfg_rx_clr_o),
    .cfg_rx_dest_o            (cfg_rx_dest_o),
    .cfg_rx_en_i              (cfg_rx_en_i),
    .cfg_rx_pending_i         (cfg_rx_pending_i),
    .cfg_rx_curr_addr_i       (cfg_rx_curr_addr_i),
    .cfg_rx_bytes_left_i      (cfg_rx_bytes_left_i),
    .cam_ip_en_i              (cam_ip_en_i),
    .cam_frame_done_i         (cam_frame_done_i),
    .cam_overflow_i           (cam_overflow_i),
    .cfg_cam_glob_o           (cfg_cam_glob_o),
    .cfg_cam_ll_o             (cfg_cam_ll_o),
    .cfg_cam_ur_o             (cfg_cam_ur_o),
    .cfg_cam_size_o           (cfg_cam_size_o),
    .cfg_cam_filter_o         (cfg_cam_filter_o),
    .cfg_cam_vsync_polarity_o (cfg_cam_vsync_polarity_o),
    .irq_o                    (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a write during the low phase; returns 1 ns after the capturing edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
    @(posedge clk_i);
    #1 cfg_valid_i = 1'b0;
  endtask

  // Combinational read sampled mid low phase, before the next edge
  task automatic rdw(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a;
    #1 d = cfg_data_o;
    cfg_valid_i = 1'b0;
  endtask

  task automatic pulse_fd();
    @(negedge clk_i);
    cam_frame_done_i = 1'b1;
    @(posedge clk_i);
    #1 cam_frame_done_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    cfg_data_i = '0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    cfg_rx_en_i = 2'b10; cfg_rx_pending_i = 2'b10;
    cfg_rx_curr_addr_i = {12'hABC, 12'h123};
    cfg_rx_bytes_left_i = {16'h4321, 16'h0042};
    cam_ip_en_i = 1'b0; cam_frame_done_i = 1'b0; cam_overflow_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ll", cfg_cam_ll_o, 32'h0);
    chk("rst_rx_en", {30'b0, cfg_rx_en_o}, 32'h0);
    chk("rst_dest", {16'b0, cfg_rx_dest_o}, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    @(negedge clk_i) rstn_i = 1'b1;

    // Channel CFG: en/clr pulses on ch1 only, datasize=1, cont=0
    wr(5'd6, 32'h52);
    chk("ch1_en_pulse", {30'b0, cfg_rx_en_o}, 32'h2);
    chk("ch1_clr_pulse", {30'b0, cfg_rx_clr_o}, 32'h2);
    chk("ch_datasize", {28'b0, cfg_rx_datasize_o}, 32'h4);
    chk("ch_cont", {30'b0, cfg_rx_continuous_o}, 32'h0);
    @(posedge clk_i); #1;
    chk("ch1_pulse_end", {28'b0, cfg_rx_en_o, cfg_rx_clr_o}, 32'h0);
    rdw(5'd6, rd);  chk("ch1_cfg_rd", rd, 32'h32);
    wr(5'd4, 32'h055);
    chk("ch1_saddr", {8'b0, cfg_rx_startaddr_o}, 32'h055000);
    rdw(5'd4, rd);  chk("ch1_saddr_rd", rd, 32'hABC);
    rdw(5'd1, rd);  chk("ch0_size_rd", rd, 32'h42);
    wr(5'd3, 32'hA5);
    chk("ch0_dest", {16'b0, cfg_rx_dest_o}, 32'h00A5);
    wr(5'd9, 32'hFFFF);
    rdw(5'd9, rd);  chk("ch2_unmapped_rd", rd, 32'h0);
    chk("ch_size_untouched", cfg_rx_size_o, 32'h0);

    // Immediate commit with camera idle
    wr(5'd17, 32'h00100020);
    chk("ll_before_commit", cfg_cam_ll_o, 32'h0);
    wr(5'd22, 32'h1);
    chk("ll_after_commit", cfg_cam_ll_o, 32'h00100020);
    rdw(5'd23, rd); chk("status_commit", rd, 32'h4);
    wr(5'd23, 32'h4);
    rdw(5'd23, rd); chk("status_w1c", rd, 32'h0);

    // Armed commit, applied at frame end
    cam_ip_en_i = 1'b1;
    wr(5'd19, 32'h1F);
    wr(5'd22, 32'h1);
    rdw(5'd22, rd); chk("commit_armed", rd, 32'h1);
    chk("size_held", cfg_cam_size_o, 32'h0);
    rdw(5'd16, rd); chk("glob_ip_en_rd", rd, 32'h80000000);
    pulse_fd();
    chk("size_applied", cfg_cam_size_o, 32'h1F);
    rdw(5'd22, rd); chk("commit_idle", rd, 32'h0);
    rdw(5'd23, rd); chk("status_fd_commit", rd, 32'h5);

    // Armed commit applied when camera stops
    wr(5'd20, 32'h77);
    wr(5'd22, 32'h1);
    @(negedge clk_i) cam_ip_en_i = 1'b0;
    @(posedge clk_i); #1;
    chk("filter_on_stop", cfg_cam_filter_o, 32'h77);
    rdw(5'd22, rd); chk("commit_idle_stop", rd, 32'h0);

    // Shadow write in the copy cycle stays in shadow only
    cam_ip_en_i = 1'b1;
    wr(5'd18, 32'h11);
    wr(5'd22, 32'h1);
    @(negedge clk_i);
    cam_frame_done_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'd18; cfg_data_i = 32'h22;
    @(posedge clk_i);
    #1 cam_frame_done_i = 1'b0; cfg_valid_i = 1'b0;
    chk("ur_pre_write", cfg_cam_ur_o, 32'h11);
    rdw(5'd18, rd); chk("ur_shadow", rd, 32'h22);

    // Frame counter wrap (4 bits) and clear-vs-increment
    wr(5'd24, 32'h0);
    for (int i = 0; i < 17; i++) pulse_fd();
    rdw(5'd24, rd); chk("fcnt_wrap", rd, 32'h1);
    @(negedge clk_i);
    cam_frame_done_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'd24; cfg_data_i = 32'h0;
    @(posedge clk_i);
    #1 cam_frame_done_i = 1'b0; cfg_valid_i = 1'b0;
    rdw(5'd24, rd); chk("fcnt_clr_wins", rd, 32'h0);

    // Status set beats same-cycle W1C; interrupt follow-up
    wr(5'd23, 32'h7);
    wr(5'd25, 32'h2);
    @(negedge clk_i);
    cam_overflow_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'd23; cfg_data_i = 32'h2;
    @(posedge clk_i);
    #1 cam_overflow_i = 1'b0; cfg_valid_i = 1'b0;
    rdw(5'd23, rd); chk("ovf_set_wins", rd, 32'h2);
`ifdef CAMERA_REG_IF_MC_IRQ_EN
    rdw(5'd25, rd); chk("irq_mask_rd", rd, 32'h2);
    @(posedge clk_i); #1;
    chk("irq_set", {31'b0, irq_o}, 32'h1);
    wr(5'd23, 32'h2);
    chk("irq_lag", {31'b0, irq_o}, 32'h1);
    @(posedge clk_i); #1;
    chk("irq_clear", {31'b0, irq_o}, 32'h0);
`else
    rdw(5'd25, rd); chk("irq_mask_absent", rd, 32'h0);
    @(posedge clk_i); #1;
    chk("irq_tied_0", {31'b0, irq_o}, 32'h0);
`endif

    // Reset while ARMED drops the pending commit
    wr(5'd16, 32'h1234);
    wr(5'd22, 32'h1);
    rdw(5'd22, rd); chk("armed_pre_rst", rd, 32'h1);
    @(negedge clk_i) rstn_i = 1'b0;
    #1;
    chk("rst_saddr", {8'b0, cfg_rx_startaddr_o}, 32'h0);
    chk("rst_ll2", cfg_cam_ll_o, 32'h0);
    chk("rst_size2", cfg_cam_size_o, 32'h0);
    chk("rst_irq2", {31'b0, irq_o}, 32'h0);
    chk("rst_commit_rd", cfg_data_o, 32'h0);
    @(negedge clk_i) rstn_i = 1'b1;
    pulse_fd();
    chk("no_copy_after_rst", cfg_cam_glob_o, 32'h0);
    rdw(5'd23, rd); chk("status_after_rst", rd, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
